// File: rtl/demux_pkg.sv
// Shared types and constants for the demux scheduler: FSM state encoding,
// mode select values and the statistics counter width.
package demux_pkg;

    localparam int unsigned STAT_W = 16;

    localparam logic MODE_RR   = 1'b0;
    localparam logic MODE_ADDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } state_e;

endpackage

// File: rtl/demux_sched_rr_pick.sv
// Ready-masked round-robin picker: grants the first requesting channel
// found by searching upward from last_i+1 and wrapping to 0.
module rr_pick #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  last_i,
    output logic [SEL_W-1:0]  grant_o,
    output logic              any_req_o
);

    logic [SEL_W-1:0] idx;
    logic             found;

    // NUM_CH is a power of two, so SEL_W-bit addition wraps the search for free.
    always_comb begin
        grant_o = last_i;
        found   = 1'b0;
        idx     = last_i;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = last_i + SEL_W'(i);
            if (!found && req_i[idx]) begin
                grant_o = idx;
                found   = 1'b1;
            end
        end
        any_req_o = |req_i;
    end

endmodule

// File: rtl/demux_sched.sv
// One-word demux scheduler: accepts a word, holds it on one output channel until
// taken or timed out. Optional statistics counters under DEMUX_SCHED_STATS_EN.
module demux_sched
    import demux_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned TIMEOUT    = 255,
    localparam int unsigned SEL_W     = $clog2(NUM_CH)
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic                  enable_i,
    input  logic                  mode_i,
    input  logic [SEL_W-1:0]      dest_i,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic [NUM_CH-1:0]     out_valid_o,
    input  logic [NUM_CH-1:0]     out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [SEL_W-1:0]      selector_o,
    output logic                  busy_o,
    output logic                  drop_o,
    output logic [STAT_W-1:0]     xfer_count_o,
    output logic [STAT_W-1:0]     drop_count_o
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [SEL_W-1:0]        last_q, last_d;
    logic [NUM_CH-1:0]       valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    drop_q, drop_d;
    logic [CNT_W-1:0]        hold_cnt_q, hold_cnt_d;

    logic [SEL_W-1:0]        rr_grant;
    logic                    rr_any;
    logic [SEL_W-1:0]        target;
    logic                    target_ok;
    logic                    accept;
    logic                    timeout_hit;
    logic                    xfer_inc;
    logic                    drop_inc;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_pick (
        .req_i     (out_ready_i),
        .last_i    (last_q),
        .grant_o   (rr_grant),
        .any_req_o (rr_any)
    );

    assign target_ok = (mode_i == MODE_ADDR) ? 1'b1 : rr_any;
    assign target    = (mode_i == MODE_ADDR) ? dest_i : rr_grant;

    // Gated by arstn_i so the upstream never sees ready while in reset.
    assign in_ready_o = arstn_i & enable_i & (state_q == IDLE) & target_ok;
    assign accept     = in_valid_i & in_ready_o;

    assign timeout_hit = (TIMEOUT != 0) &&
                         ((32'(hold_cnt_q) + 32'd1) == 32'(TIMEOUT));

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sel_d      = sel_q;
        last_d     = last_q;
        valid_d    = valid_q;
        hold_cnt_d = hold_cnt_q;
        drop_d     = 1'b0;
        xfer_inc   = 1'b0;
        drop_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d     = in_data_i;
                    sel_d      = target;
                    valid_d    = NUM_CH'(1) << target;
                    hold_cnt_d = '0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                // A completing transfer wins over a timeout in the same cycle.
                if (out_ready_i[sel_q]) begin
                    valid_d  = '0;
                    last_d   = sel_q;
                    xfer_inc = 1'b1;
                    state_d  = IDLE;
                end else if (timeout_hit) begin
                    valid_d  = '0;
                    drop_d   = 1'b1;
                    drop_inc = 1'b1;
                    state_d  = DROP;
                end else if (TIMEOUT != 0) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            DROP: begin
                state_d = IDLE;
            end
            default: begin
                valid_d = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= IDLE;
            data_q     <= '0;
            sel_q      <= '0;
            last_q     <= SEL_W'(NUM_CH - 1);
            valid_q    <= '0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign selector_o  = sel_q;
    assign busy_o      = busy_q;
    assign drop_o      = drop_q;

`ifdef DEMUX_SCHED_STATS_EN
    logic [STAT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic [STAT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Saturating event counters.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (xfer_inc && (xfer_cnt_q != '1)) begin
            xfer_cnt_d = xfer_cnt_q + STAT_W'(1);
        end
        if (drop_inc && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            xfer_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign xfer_count_o = xfer_cnt_q;
    assign drop_count_o = drop_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = xfer_inc ^ drop_inc;
    assign xfer_count_o = '0;
    assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_demux_sched.sv
// Directed bench for demux_sched (NUM_CH=8, TIMEOUT=4); counter expectations
// follow whether DEMUX_SCHED_STATS_EN is defined.
module tb_demux_sched;

`ifdef DEMUX_SCHED_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        clk;
    logic        arstn;
    logic        enable;
    logic        mode;
    logic [2:0]  dest;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [31:0] out_data;
    logic [2:0]  selector;
    logic        busy;
    logic        drop;
    logic [15:0] xfer_count;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;

    demux_sched #(
        .DATA_WIDTH (32),
        .NUM_CH     (8),
        .TIMEOUT    (4)
    ) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .enable_i     (enable),
        .mode_i       (mode),
        .dest_i       (dest),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .selector_o   (selector),
        .busy_o       (busy),
        .drop_o       (drop),
        .xfer_count_o (xfer_count),
        .drop_count_o (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] sx(input int n);
        return STATS_ON ? 32'(n) : 32'd0;
    endfunction

    initial begin
        arstn     = 1'b0;
        enable    = 1'b0;
        mode      = 1'b0;
        dest      = 3'd0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 8'h00;

        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_selector", 32'(selector), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_xfer_cnt", 32'(xfer_count), 32'd0);
        chk("rst_drop_cnt", 32'(drop_count), 32'd0);
        arstn = 1'b1;
        tick();

        // Round-robin, all channels ready, 10 back-to-back words
        enable    = 1'b1;
        mode      = 1'b0;
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'hA000_0000 + 32'(i);
            #1;
            chk("rr_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("rr_selector", 32'(selector), 32'(i % 8));
            chk("rr_out_valid", 32'(out_valid), 32'(8'h01 << (i % 8)));
            chk("rr_out_data", out_data, 32'hA000_0000 + 32'(i));
            chk("rr_busy", 32'(busy), 32'd1);
            tick();
            chk("rr_done_valid", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        chk("rr_xfer_cnt", 32'(xfer_count), sx(10));

        // Addressed mode to channel 5
        mode      = 1'b1;
        dest      = 3'd5;
        in_data   = 32'hCAFE0005;
        out_ready = 8'h20;
        in_valid  = 1'b1;
        #1;
        chk("addr_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("addr_out_valid", 32'(out_valid), 32'h20);
        chk("addr_selector", 32'(selector), 32'd5);
        chk("addr_out_data", out_data, 32'hCAFE0005);
        chk("addr_hold_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("addr_done_valid", 32'(out_valid), 32'd0);
        chk("addr_done_busy", 32'(busy), 32'd0);
        chk("addr_xfer_cnt", 32'(xfer_count), sx(11));

        // Park last_served at 2, then round-robin over ready mask 0001_0100
        dest      = 3'd2;
        out_ready = 8'h04;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("park_selector", 32'(selector), 32'd2);
        tick();
        mode      = 1'b0;
        out_ready = 8'b0001_0100;
        in_valid  = 1'b1;
        #1;
        chk("mask_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("mask_sel_first", 32'(selector), 32'd4);
        chk("mask_valid_first", 32'(out_valid), 32'h10);
        tick();
        tick();
        in_valid = 1'b0;
        chk("mask_sel_second", 32'(selector), 32'd2);
        chk("mask_valid_second", 32'(out_valid), 32'h04);
        tick();
        chk("mask_xfer_cnt", 32'(xfer_count), sx(14));

        // Timeout: channel 3 never ready -> DROP after 4 HOLD cycles
        mode      = 1'b1;
        dest      = 3'd3;
        out_ready = 8'h00;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("to_valid_c1", 32'(out_valid), 32'h08);
        tick();
        tick();
        tick();
        chk("to_valid_c4", 32'(out_valid), 32'h08);
        chk("to_drop_c4", 32'(drop), 32'd0);
        tick();
        chk("to_drop_pulse", 32'(drop), 32'd1);
        chk("to_drop_valid", 32'(out_valid), 32'd0);
        chk("to_drop_busy", 32'(busy), 32'd1);
        tick();
        chk("to_drop_end", 32'(drop), 32'd0);
        chk("to_idle_busy", 32'(busy), 32'd0);
        chk("to_drop_cnt", 32'(drop_count), sx(1));
        chk("to_xfer_cnt", 32'(xfer_count), sx(14));

        // Ready arrives in the 4th HOLD cycle: transfer wins, no drop
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        out_ready = 8'h08;
        chk("edge_still_hold", 32'(out_valid), 32'h08);
        tick();
        chk("edge_no_drop", 32'(drop), 32'd0);
        chk("edge_valid_done", 32'(out_valid), 32'd0);
        chk("edge_busy", 32'(busy), 32'd0);
        tick();
        chk("edge_no_drop_late", 32'(drop), 32'd0);
        chk("edge_drop_cnt", 32'(drop_count), sx(1));
        chk("edge_xfer_cnt", 32'(xfer_count), sx(15));

        // enable_i dropped during HOLD: transfer still completes
        dest      = 3'd1;
        out_ready = 8'h00;
        in_valid  = 1'b1;
        tick();
        enable = 1'b0;
        chk("en_hold_valid", 32'(out_valid), 32'h02);
        tick();
        chk("en_still_hold", 32'(busy), 32'd1);
        out_ready = 8'h02;
        tick();
        chk("en_done_valid", 32'(out_valid), 32'd0);
        chk("en_in_ready", 32'(in_ready), 32'd0);
        chk("en_xfer_cnt", 32'(xfer_count), sx(16));
        tick();
        chk("en_no_accept", 32'(busy), 32'd0);
        chk("en_in_ready_late", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        enable   = 1'b1;

        // Reset asserted mid-HOLD
        dest      = 3'd6;
        out_ready = 8'h00;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mr_hold_valid", 32'(out_valid), 32'h40);
        #2;
        arstn = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_selector", 32'(selector), 32'd0);
        chk("mr_out_data", out_data, 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd0);
        chk("mr_xfer_cnt", 32'(xfer_count), 32'd0);
        chk("mr_drop_cnt", 32'(drop_count), 32'd0);
        tick();
        tick();
        arstn     = 1'b1;
        mode      = 1'b0;
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        in_data   = 32'h0000_BEEF;
        #1;
        chk("post_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("post_selector", 32'(selector), 32'd0);
        chk("post_valid", 32'(out_valid), 32'h01);
        chk("post_xfer_pre", 32'(xfer_count), 32'd0);
        tick();
        chk("post_xfer_cnt", 32'(xfer_count), sx(1));
        chk("post_drop_cnt", 32'(drop_count), 32'd0);
        chk("post_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
